// File: rtl/keypad16_scanner_pkg.sv
// Shared keypad16 definitions (keypad16_defs): matrix geometry, scan-state encoding,
// idle row drive pattern and a helper that classifies a debounced key vector.
package keypad16_scanner_pkg;

    localparam int ROW_COUNT = 4;
    localparam int COL_COUNT = 4;
    localparam int KEY_COUNT = ROW_COUNT * COL_COUNT;

    localparam logic [ROW_COUNT-1:0] ROWS_RESET = 4'b1110;

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2,
        ROW3 = 2'd3
    } scanState_e;

    typedef enum logic [1:0] {
        KEY_NONE = 2'd0,
        KEY_ONE  = 2'd1,
        KEY_MANY = 2'd2
    } keyClass_e;

    function automatic logic [ROW_COUNT-1:0] rowDrive(input scanState_e state);
        rowDrive = ~(4'b0001 << state);
    endfunction

    // v & (v-1) clears the lowest set bit, so a zero result means at most one key is down.
    function automatic keyClass_e keyClass(input logic [KEY_COUNT-1:0] v);
        if (v == '0) begin
            keyClass = KEY_NONE;
        end else if ((v & (v - 16'd1)) == '0) begin
            keyClass = KEY_ONE;
        end else begin
            keyClass = KEY_MANY;
        end
    endfunction

endpackage

// File: rtl/keypad16_scanner_debounce.sv
// Column synchronizer plus snapshot assembly and stable-scan counting for the keypad16 scanner.
module keypad16_debounce
    import keypad16_scanner_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [COL_COUNT-1:0] cols_i,
    input  logic                 sample_i,
    input  scanState_e           row_i,
    input  logic                 wrap_i,
    output logic                 accept_o,
    output logic [KEY_COUNT-1:0] state_o
);

    localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_SCANS);

    logic [COL_COUNT-1:0] colsMeta_q;
    logic [COL_COUNT-1:0] colsSync_q;
    logic [KEY_COUNT-1:0] snap_q,   snap_d;
    logic [KEY_COUNT-1:0] prev_q,   prev_d;
    logic [3:0]           stable_q, stable_d;
    logic                 accept_q, accept_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            colsMeta_q <= '1;
            colsSync_q <= '1;
            snap_q     <= '0;
            prev_q     <= '0;
            stable_q   <= '0;
            accept_q   <= 1'b0;
        end else begin
            colsMeta_q <= cols_i;
            colsSync_q <= colsMeta_q;
            snap_q     <= snap_d;
            prev_q     <= prev_d;
            stable_q   <= stable_d;
            accept_q   <= accept_d;
        end
    end

    // On the wrap the ROW3 nibble is captured in the same clock, so compare the updated snapshot.
    always_comb begin
        snap_d   = snap_q;
        prev_d   = prev_q;
        stable_d = stable_q;
        accept_d = 1'b0;
        if (sample_i) begin
            snap_d[int'(row_i)*COL_COUNT +: COL_COUNT] = ~colsSync_q;
        end
        if (wrap_i) begin
            if (snap_d == prev_q) begin
                if (stable_q != STABLE_MAX) begin
                    stable_d = stable_q + 4'd1;
                    accept_d = ((stable_q + 4'd1) == STABLE_MAX);
                end
            end else begin
                stable_d = '0;
                prev_d   = snap_d;
            end
        end
    end

    assign accept_o = accept_q;
    assign state_o  = prev_q;

endmodule

// File: rtl/keypad16_scanner.sv
// 4x4 keypad row scanner with debounced one-hot key output and multi-key flag.
// Define KEYPAD16_SCANNER_REPEAT_EN to add auto-repeat of key_valid while a key is held.
module keypad16_scanner
    import keypad16_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int REPEAT_SCANS   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [ROW_COUNT-1:0] rows,
    input  logic [COL_COUNT-1:0] cols,
    output logic [KEY_COUNT-1:0] keys,
    output logic                 key_valid,
    output logic                 multi
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_badParams
        $error("keypad16_scanner: illegal parameter value");
    end

    scanState_e             state_q,  state_d;
    logic [DIV_W-1:0]       divCnt_q, divCnt_d;
    logic [KEY_COUNT-1:0]   keys_q,   keys_d;
    logic                   multi_q,  multi_d;
    logic                   valid_q,  valid_d;
    logic                   lastSlot;
    logic                   wrap;
    logic                   accept;
    logic [KEY_COUNT-1:0]   debState;

    assign lastSlot = (divCnt_q == DIV_LAST);
    assign wrap     = lastSlot && (state_q == ROW3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ROW0;
            divCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            divCnt_q <= divCnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        divCnt_d = divCnt_q + DIV_W'(1);
        if (lastSlot) begin
            divCnt_d = '0;
            case (state_q)
                ROW0:    state_d = ROW1;
                ROW1:    state_d = ROW2;
                ROW2:    state_d = ROW3;
                default: state_d = ROW0;
            endcase
        end
    end

    assign rows = rowDrive(state_q);

    keypad16_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .cols_i  (cols),
        .sample_i(lastSlot),
        .row_i   (state_q),
        .wrap_i  (wrap),
        .accept_o(accept),
        .state_o (debState)
    );

`ifdef KEYPAD16_SCANNER_REPEAT_EN
    localparam int REP_W = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);

    logic [REP_W-1:0] repCnt_q, repCnt_d;
    logic             wrapDly_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            keys_q    <= '0;
            multi_q   <= 1'b0;
            valid_q   <= 1'b0;
`ifdef KEYPAD16_SCANNER_REPEAT_EN
            repCnt_q  <= '0;
            wrapDly_q <= 1'b0;
`endif
        end else begin
            keys_q    <= keys_d;
            multi_q   <= multi_d;
            valid_q   <= valid_d;
`ifdef KEYPAD16_SCANNER_REPEAT_EN
            repCnt_q  <= repCnt_d;
            wrapDly_q <= wrap;
`endif
        end
    end

    // A multi-key state parks keys at 0, so returning to a single key counts as a new event.
    // Repeat ticks use the delayed wrap so they land one clock after a wrap, like accepts do.
    always_comb begin
        keys_d  = keys_q;
        multi_d = multi_q;
        valid_d = 1'b0;
`ifdef KEYPAD16_SCANNER_REPEAT_EN
        repCnt_d = repCnt_q;
`endif
        if (accept) begin
            case (keyClass(debState))
                KEY_NONE: begin
                    keys_d  = '0;
                    multi_d = 1'b0;
                end
                KEY_ONE: begin
                    keys_d  = debState;
                    multi_d = 1'b0;
                end
                default: begin
                    keys_d  = '0;
                    multi_d = 1'b1;
                end
            endcase
            valid_d = (keys_d != '0) && (keys_d != keys_q);
        end
`ifdef KEYPAD16_SCANNER_REPEAT_EN
        if ((keys_d != keys_q) || (keys_q == '0)) begin
            repCnt_d = '0;
        end else if (wrapDly_q) begin
            if (repCnt_q == REP_LAST) begin
                repCnt_d = '0;
                valid_d  = 1'b1;
            end else begin
                repCnt_d = repCnt_q + REP_W'(1);
            end
        end
`endif
    end

    assign keys      = keys_q;
    assign multi     = multi_q;
    assign key_valid = valid_q;

endmodule

// File: tb/tb_keypad16_scanner.sv
// Scoreboard bench for keypad16_scanner: a key-matrix model drives cols from rows, expected
// key codes are queued with each press and popped on every key_valid pulse.
`timescale 1ns/1ps
module tb_keypad16_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [15:0] keys;
    logic        key_valid;
    logic        multi;

    logic [15:0] pressed = '0;
    logic [15:0] expQ[$];
    int          pulseTimes[$];
    int          totalChecks = 0;
    int          badChecks = 0;
    int          pulseCount = 0;
    int          cycle = 0;

    always #5 clk = ~clk;

    keypad16_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3),
        .REPEAT_SCANS  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rows     (rows),
        .cols     (cols),
        .keys     (keys),
        .key_valid(key_valid),
        .multi    (multi)
    );

    // Key matrix: a pressed key shorts its column low while its row is driven low.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!rows[r] && pressed[r*4+c]) cols[c] = 1'b0;
            end
        end
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        totalChecks++;
        if (got !== want) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] mask);
        pressed = mask;
    endtask

    task automatic stepClock();
        @(negedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) stepClock();
    endtask

    task automatic waitPulse(input string tag, input int budget);
        int start;
        int n;
        start = pulseCount;
        n = 0;
        while (pulseCount == start && n < budget) begin
            stepClock();
            n++;
        end
        checkOutput(tag, pulseCount - start, 1);
    endtask

    // Monitor: every key_valid pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                pulseCount++;
                pulseTimes.push_back(cycle);
                checkOutput("pulseExpected", expQ.size() > 0, 1);
                if (expQ.size() > 0) begin
                    checkOutput("pulseKeys", keys, expQ.pop_front());
                    checkOutput("pulseMulti", multi, 0);
                end
            end
        end
    end

    initial begin
        int start;
        int n;
        logic [3:0] expRows;

        // Reset state
        applyStimulus(16'h0000);
        rst_n = 1'b0;
        waitCycles(5);
        checkOutput("resetRows", rows, 4'b1110);
        checkOutput("resetKeys", keys, 16'h0000);
        checkOutput("resetMulti", multi, 0);
        checkOutput("resetValid", key_valid, 0);

        // Idle scan sequence
        rst_n = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            stepClock();
            expRows = ~(4'b0001 << ((i / 4) % 4));
            checkOutput("rowsSeq", rows, expRows);
        end
        checkOutput("idleKeys", keys, 16'h0000);
        checkOutput("idlePulses", pulseCount, 0);

        // Single key press and release
        $display("[TB] single key");
        expQ.push_back(16'h0020);
        applyStimulus(16'h0020);
        waitPulse("singlePress", 83);
        checkOutput("singleKeys", keys, 16'h0020);
        checkOutput("singleMulti", multi, 0);
        start = pulseCount;
        applyStimulus(16'h0000);
        n = 0;
        while (keys != 16'h0000 && n < 83) begin
            stepClock();
            n++;
        end
        checkOutput("releaseKeys", keys, 16'h0000);
        checkOutput("releaseNoPulse", pulseCount - start, 0);
        waitCycles(40);

        // Bounce
        $display("[TB] bounce");
        start = pulseCount;
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2 == 0) ? 16'h0020 : 16'h0000);
            waitCycles(10);
        end
        checkOutput("bounceNoPulse", pulseCount - start, 0);
        checkOutput("bounceKeys", keys, 16'h0000);
        expQ.push_back(16'h0020);
        applyStimulus(16'h0020);
        waitPulse("bounceSettle", 83);
        waitCycles(20);
        checkOutput("bounceOnePulse", pulseCount - start, 1);
        applyStimulus(16'h0000);
        waitCycles(100);
        checkOutput("bounceRelease", keys, 16'h0000);

        // Multi-key
        $display("[TB] multi key");
        start = pulseCount;
        applyStimulus(16'h8001);
        waitCycles(100);
        checkOutput("multiKeys", keys, 16'h0000);
        checkOutput("multiFlag", multi, 1);
        checkOutput("multiNoPulse", pulseCount - start, 0);
        expQ.push_back(16'h0001);
        applyStimulus(16'h0001);
        waitPulse("multiToSingle", 83);
        checkOutput("singleAfterMulti", keys, 16'h0001);
        checkOutput("multiCleared", multi, 0);
        applyStimulus(16'h0000);
        waitCycles(100);
        checkOutput("multiRelease", keys, 16'h0000);

        // Reset during ROW2 with key 10 held
        $display("[TB] reset mid-scan");
        expQ.push_back(16'h0400);
        applyStimulus(16'h0400);
        waitPulse("preResetPress", 83);
        n = 0;
        while (rows != 4'b1011 && n < 20) begin
            stepClock();
            n++;
        end
        checkOutput("reachRow2", rows, 4'b1011);
        stepClock();
        rst_n = 1'b0;
        stepClock();
        checkOutput("midResetRows", rows, 4'b1110);
        checkOutput("midResetKeys", keys, 16'h0000);
        checkOutput("midResetMulti", multi, 0);
        checkOutput("midResetValid", key_valid, 0);
        waitCycles(2);
        rst_n = 1'b1;
        start = pulseCount;
        expQ.push_back(16'h0400);
        waitPulse("postResetPress", 83);
        checkOutput("postResetKeys", keys, 16'h0400);
        checkOutput("postResetOnePulse", pulseCount - start, 1);
        applyStimulus(16'h0000);
        waitCycles(100);
        checkOutput("postResetRelease", keys, 16'h0000);

        // Long hold of key 3
        $display("[TB] long hold");
        pulseTimes.delete();
        start = pulseCount;
`ifdef KEYPAD16_SCANNER_REPEAT_EN
        for (int i = 0; i < 5; i++) expQ.push_back(16'h0008);
        applyStimulus(16'h0008);
        waitPulse("holdInitial", 83);
        for (int i = 0; i < 4; i++) waitPulse("holdRepeat", 130);
        checkOutput("holdPulses", pulseCount - start, 5);
        for (int k = 1; k < pulseTimes.size(); k++) begin
            checkOutput("repeatGap", pulseTimes[k] - pulseTimes[k-1], 128);
        end
`else
        expQ.push_back(16'h0008);
        applyStimulus(16'h0008);
        waitPulse("holdInitial", 83);
        waitCycles(560);
        checkOutput("holdPulses", pulseCount - start, 1);
`endif
        checkOutput("holdKeys", keys, 16'h0008);
        applyStimulus(16'h0000);
        waitCycles(100);
        checkOutput("holdRelease", keys, 16'h0000);
        checkOutput("pendingExpect", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
